// File: rtl/ex_div.sv
// Multi-cycle 32-bit divider for the execute stage: restoring radix-2, one quotient bit per
// clock, signed (DIV) and unsigned (DIVU), with divide-by-zero short cut and flush support.
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {StIdle, StByZero, StOn, StEnd} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] divisor_q, divisor_d;
    logic        a_neg_q, a_neg_d;
    logic        b_neg_q, b_neg_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [32:0] diff;
    logic [31:0] dividend_abs, divisor_abs;
    logic [31:0] quo_raw, rem_raw, quo_fix, rem_fix;

    assign diff = {1'b0, work_q[63:32]} - {1'b0, divisor_q};

    assign dividend_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign divisor_abs  = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    // Sign flags are only ever set for signed operations, so they double as the signed mode.
    assign quo_raw = work_q[31:0];
    assign rem_raw = work_q[64:33];
    assign quo_fix = (a_neg_q ^ b_neg_q) ? (~quo_raw + 32'd1) : quo_raw;
    assign rem_fix = a_neg_q ? (~rem_raw + 32'd1) : rem_raw;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        result_d  = result_q;
        ready_d   = ready_q;

        unique case (state_q)
            StIdle: begin
                if (start_i && !annul_i) begin
                    state_d   = (opdata2_i == 32'd0) ? StByZero : StOn;
                    cnt_d     = 6'd0;
                    work_d    = {32'd0, dividend_abs, 1'b0};
                    divisor_d = divisor_abs;
                    a_neg_d   = signed_div_i & opdata1_i[31];
                    b_neg_d   = signed_div_i & opdata2_i[31];
                end
            end
            StByZero: begin
                result_d = 64'd0;
                if (annul_i) begin
                    state_d = StIdle;
                    ready_d = 1'b0;
                end else begin
                    state_d = StEnd;
                    ready_d = 1'b1;
                end
            end
            StOn: begin
                if (annul_i) begin
                    state_d  = StIdle;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end else if (cnt_q == 6'd32) begin
                    state_d  = StEnd;
                    ready_d  = 1'b1;
                    result_d = {rem_fix, quo_fix};
                end else begin
                    // Borrow out of the 33-bit subtract means the divisor did not fit.
                    if (diff[32]) begin
                        work_d = work_q << 1;
                    end else begin
                        work_d = {diff[31:0], work_q[31:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end
            end
            StEnd: begin
                if (!start_i) begin
                    state_d  = StIdle;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= 6'd0;
            work_q    <= 65'd0;
            divisor_q <= 32'd0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            result_q  <= 64'd0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            a_neg_q   <= a_neg_d;
            b_neg_q   <= b_neg_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = (state_q == StOn) || (state_q == StByZero);

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: driver pushes reference results on acceptance, monitor pops
// and compares on each rising ready_o; driver also checks latency, busy_o and handshake.
module tb_ex_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int          n_vec;
    int          n_err;
    logic [63:0] exp_q[$];
    logic        ready_prev;

    ex_div u_dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division, truncating toward zero, remainder follows dividend.
    function automatic logic [63:0] model(input logic s, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, req);
        end
    endtask

    // Monitor: one comparison per result presentation.
    always @(negedge clk) begin
        if (rst && ready_o && !ready_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", result_o, 64'hx);
            end else begin
                check("result", result_o, exp_q.pop_front());
            end
        end
        ready_prev <= ready_o;
    end

    // Full transaction with start held until ready_o, then released.
    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b);
        int cycles, busy_cnt, lat;
        lat = (b == 32'd0) ? 1 : 33;
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(s, a, b));
        #1;
        cycles   = 0;
        busy_cnt = 0;
        while (!ready_o && cycles < 100) begin
            busy_cnt += int'(busy_o);
            signed_div_i = 1'($urandom);
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            @(posedge clk);
            #1;
            cycles++;
        end
        check("latency", 64'(cycles), 64'(lat));
        check("busy_cycles", 64'(busy_cnt), 64'(lat));
        check("busy_in_end", 64'(busy_o), 64'd0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        check("ready_held", 64'(ready_o), 64'd1);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("ready_drop", {63'd0, ready_o}, 64'd0);
        check("result_clear", result_o, 64'd0);
    endtask

    task automatic rand_op();
        logic        s;
        logic [31:0] a, b;
        s = 1'($urandom);
        a = $urandom;
        case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = $urandom_range(1, 15);
            2: b = 32'hFFFFFFFF - $urandom_range(0, 15);
            3: b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
        endcase
        if ($urandom_range(0, 7) == 0) a = 32'h80000000;
        do_op(s, a, b);
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        ready_prev   = 1'b0;
        rst          = 1'b0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        #1;
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        check("reset_busy", {63'd0, busy_o}, 64'd0);
        check("reset_result", result_o, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        do_op(1'b0, 32'd100, 32'd7);
        do_op(1'b1, 32'hFFFFFFF9, 32'd2);
        do_op(1'b1, 32'd7, 32'hFFFFFFFE);
        do_op(1'b1, 32'h80000000, 32'hFFFFFFFF);
        do_op(1'b0, 32'h12345678, 32'd0);
        do_op(1'b1, 32'h80000000, 32'd0);

        // Flush at cnt=10, then a fresh operation the following cycle.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        annul_i = 1'b0;
        check("annul_busy", {63'd0, busy_o}, 64'd0);
        check("annul_ready", {63'd0, ready_o}, 64'd0);
        do_op(1'b0, 32'hFFFFFFFF, 32'd1);

        // Asynchronous reset between edges at cnt=20.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'hDEADBEEF;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #2;
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy_o}, 64'd0);
        check("arst_ready", {63'd0, ready_o}, 64'd0);
        check("arst_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("post_reset_idle", {62'd0, ready_o, busy_o}, 64'd0);

        for (int i = 0; i < 40; i++) rand_op();

        repeat (3) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
